// File: rtl/score_keeper_pkg.sv
// ============================================================================
// Module : score_pkg
// Shared types and constants for the height-score accumulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package score_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        COMMIT = 2'd2
    } score_state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int         MAX_DIGITS    = 8;

    // Callers slice the low 4*digits bits of the fixed-width result.
    function automatic logic [4*MAX_DIGITS-1:0] all_nines(input int digits);
        logic [4*MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) v[4*i +: 4] = BCD_DIGIT_MAX;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_keeper_if.sv
// ============================================================================
// Module : score_keeper_if
// Frame/game control inputs and BCD score outputs of the score keeper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface score_keeper_if #(
    parameter int DIGITS = 4,
    parameter int DISP_W = 8
) ();
    logic                  frame_clk;
    logic [DISP_W-1:0]     displacement;
    logic                  game_over;
    logic                  new_game;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [4*DIGITS-1:0]   high_bcd;
    logic                  busy;
    logic                  overflow;

    modport master (
        output frame_clk, displacement, game_over, new_game,
        input  score_bcd, high_bcd, busy, overflow
    );

    modport slave (
        input  frame_clk, displacement, game_over, new_game,
        output score_bcd, high_bcd, busy, overflow
    );
endinterface

`default_nettype wire

// File: rtl/score_keeper_bcd_incrementer.sv
// ============================================================================
// Module : bcd_incrementer
// Combinational packed-BCD +1 with ripple carry; carry_out flags all-9s input.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_incrementer
    import score_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  wire logic [4*DIGITS-1:0] value_i,
    output logic      [4*DIGITS-1:0] value_inc_o,
    output logic                     carry_out_o
);

    logic [DIGITS:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] d;
        assign d                  = value_i[4*i +: 4];
        assign value_inc_o[4*i +: 4] = !carry[i] ? d :
                                       ((d >= BCD_DIGIT_MAX) ? 4'd0 : d + 4'd1);
        assign carry[i+1]         = carry[i] & (d >= BCD_DIGIT_MAX);
    end

    assign carry_out_o = carry[DIGITS];

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// Module : score_keeper
// Accumulates per-frame scroll into a saturating BCD score and keeps a high score.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module score_keeper
    import score_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DISP_W = 8
) (
    input  wire logic     Clk,
    input  wire logic     Reset_n,
    score_keeper_if.slave bus
);

    localparam int PW = DISP_W + 1;
    localparam int SW = PW + 1;
    localparam logic [4*MAX_DIGITS-1:0] ALL9_FULL = all_nines(DIGITS);
    localparam logic [4*DIGITS-1:0]     SAT       = ALL9_FULL[4*DIGITS-1:0];
    localparam logic [PW-1:0]           PEND_MAX  = '1;

    logic fs1_q, fs2_q, fs3_q, tick_q, go_prev_q;
    logic commit_req_q, commit_req_d;
    logic overflow_q, overflow_d;
    logic [PW-1:0]       pend_q, pend_d;
    logic [SW-1:0]       pend_sum;
    logic [4*DIGITS-1:0] score_q, score_d, high_q, high_d, score_inc;
    logic                score_carry;
    score_state_t        state_q, state_d;
    logic                do_add, do_commit, busy, go_rise, tick_acc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs1_q     <= 1'b0;
            fs2_q     <= 1'b0;
            fs3_q     <= 1'b0;
            tick_q    <= 1'b0;
            go_prev_q <= 1'b0;
        end else begin
            fs1_q     <= bus.frame_clk;
            fs2_q     <= fs1_q;
            fs3_q     <= fs2_q;
            tick_q    <= fs2_q & ~fs3_q;
            go_prev_q <= bus.game_over;
        end
    end

    assign go_rise  = bus.game_over & ~go_prev_q;
    assign tick_acc = tick_q & ~bus.game_over & ~bus.new_game;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A game_over rise seen while points are pending is held in commit_req_q
    // so the commit happens only after the final points have drained.
    always_comb begin
        state_d = state_q;
        if (bus.new_game) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_q != '0)                  state_d = ADD;
                    else if (commit_req_q || go_rise)  state_d = COMMIT;
                end
                ADD:     if (pend_d == '0) state_d = IDLE;
                COMMIT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        do_add    = (state_q == ADD);
        do_commit = (state_q == COMMIT);
        busy      = (state_q == ADD);
    end

    bcd_incrementer #(.DIGITS(DIGITS)) u_inc (
        .value_i     (score_q),
        .value_inc_o (score_inc),
        .carry_out_o (score_carry)
    );

    always_comb begin
        pend_sum = {1'b0, pend_q} + SW'(tick_acc ? bus.displacement : '0) - SW'(do_add);
        pend_d   = (pend_sum > {1'b0, PEND_MAX}) ? PEND_MAX : pend_sum[PW-1:0];
        score_d      = score_q;
        overflow_d   = overflow_q;
        high_d       = high_q;
        commit_req_d = commit_req_q;
        if (do_commit && (score_q > high_q)) high_d = score_q;
        if (bus.new_game) begin
            pend_d       = '0;
            score_d      = '0;
            overflow_d   = 1'b0;
            commit_req_d = 1'b0;
        end else begin
            if (do_add) begin
                if (score_carry) begin
                    score_d    = SAT;
                    overflow_d = 1'b1;
                end else begin
                    score_d    = score_inc;
                end
            end
            if (state_d == COMMIT) commit_req_d = 1'b0;
            else if (go_rise)      commit_req_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_q       <= '0;
            score_q      <= '0;
            high_q       <= '0;
            overflow_q   <= 1'b0;
            commit_req_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            score_q      <= score_d;
            high_q       <= high_d;
            overflow_q   <= overflow_d;
            commit_req_q <= commit_req_d;
        end
    end

    assign bus.score_bcd = score_q;
    assign bus.high_bcd  = high_q;
    assign bus.busy      = busy;
    assign bus.overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module : tb_score_keeper
// Self-checking bench: vector table, timing corner cases, randomized model check.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_score_keeper;

    localparam int OP_VS = 0;
    localparam int OP_GO = 1;
    localparam int OP_NG = 2;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    int   m_score, m_high;
    logic m_ovf, m_go;

    score_keeper_if #(.DIGITS(4), .DISP_W(8)) bus ();

    score_keeper #(.DIGITS(4), .DISP_W(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          op;
        int          disp;
        logic [15:0] score;
        logic [15:0] high;
        logic        ovf;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while (bus.busy && c < 2000) begin
            step(1);
            c++;
        end
        chk("drain_done", {31'd0, bus.busy}, 32'd0);
        step(3);
    endtask

    task automatic do_vs(input int disp);
        bus.displacement = 8'(disp);
        bus.frame_clk    = 1'b1;
        step(6);
        bus.frame_clk    = 1'b0;
        step(6);
        wait_drain();
        if (!m_go) begin
            m_score = m_score + disp;
            if (m_score > 9999) begin
                m_score = 9999;
                m_ovf   = 1'b1;
            end
        end
    endtask

    task automatic do_go();
        bus.game_over = 1'b1;
        step(3);
        if (!m_go && m_score > m_high) m_high = m_score;
        m_go = 1'b1;
    endtask

    task automatic do_ng();
        bus.new_game = 1'b1;
        step(1);
        bus.new_game  = 1'b0;
        bus.game_over = 1'b0;
        step(2);
        m_score = 0;
        m_ovf   = 1'b0;
        m_go    = 1'b0;
    endtask

    task automatic apply(input int op, input int disp);
        case (op)
            OP_VS:   do_vs(disp);
            OP_GO:   do_go();
            default: do_ng();
        endcase
    endtask

    initial begin
        int busy_cnt;
        bus.frame_clk = 1'b0; bus.displacement = '0;
        bus.game_over = 1'b0; bus.new_game = 1'b0;
        m_score = 0; m_high = 0; m_ovf = 1'b0; m_go = 1'b0;

        tbl[0]  = '{OP_NG, 0,   16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{OP_VS, 199, 16'h0199, 16'h0000, 1'b0};
        tbl[2]  = '{OP_VS, 3,   16'h0202, 16'h0000, 1'b0};
        tbl[3]  = '{OP_GO, 0,   16'h0202, 16'h0202, 1'b0};
        tbl[4]  = '{OP_VS, 50,  16'h0202, 16'h0202, 1'b0};
        tbl[5]  = '{OP_NG, 0,   16'h0000, 16'h0202, 1'b0};
        tbl[6]  = '{OP_VS, 200, 16'h0200, 16'h0202, 1'b0};
        tbl[7]  = '{OP_VS, 140, 16'h0340, 16'h0202, 1'b0};
        tbl[8]  = '{OP_GO, 0,   16'h0340, 16'h0340, 1'b0};
        tbl[9]  = '{OP_NG, 0,   16'h0000, 16'h0340, 1'b0};
        tbl[10] = '{OP_VS, 0,   16'h0000, 16'h0340, 1'b0};
        tbl[11] = '{OP_VS, 255, 16'h0255, 16'h0340, 1'b0};

        step(3);
        Reset_n = 1'b1;
        step(1);
        chk("reset_score", {16'd0, bus.score_bcd}, 32'd0);
        chk("reset_high",  {16'd0, bus.high_bcd},  32'd0);
        chk("reset_busy",  {31'd0, bus.busy},      32'd0);
        chk("reset_ovf",   {31'd0, bus.overflow},  32'd0);

        // VS of 25 from reset: first increment 6 cycles after the rise
        busy_cnt = 0;
        bus.displacement = 8'd25;
        bus.frame_clk    = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step(1);
            if (cyc == 6) bus.frame_clk = 1'b0;
            if (bus.busy) busy_cnt++;
            if (cyc == 4)  chk("t25_busy_c4",   {31'd0, bus.busy}, 32'd0);
            if (cyc == 5)  chk("t25_busy_c5",   {31'd0, bus.busy}, 32'd1);
            if (cyc == 29) chk("t25_score_c29", {16'd0, bus.score_bcd}, 32'h0024);
            if (cyc == 30) chk("t25_score_c30", {16'd0, bus.score_bcd}, 32'h0025);
        end
        chk("t25_busy_cycles", busy_cnt, 25);

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].op, tbl[i].disp);
            chk($sformatf("vec%0d_score", i), {16'd0, bus.score_bcd}, {16'd0, tbl[i].score});
            chk($sformatf("vec%0d_high", i),  {16'd0, bus.high_bcd},  {16'd0, tbl[i].high});
            chk($sformatf("vec%0d_ovf", i),   {31'd0, bus.overflow},  {31'd0, tbl[i].ovf});
        end

        // Build 9998 then push past all-9s
        do_ng();
        for (int f = 0; f < 39; f++) do_vs(255);
        do_vs(53);
        chk("sat_pre_score", {16'd0, bus.score_bcd}, 32'h9998);
        chk("sat_pre_ovf",   {31'd0, bus.overflow},  32'd0);
        busy_cnt = 0;
        bus.displacement = 8'd5;
        bus.frame_clk    = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            step(1);
            if (cyc == 6) bus.frame_clk = 1'b0;
            if (bus.busy) busy_cnt++;
        end
        chk("sat_busy_cycles", busy_cnt, 5);
        chk("sat_score", {16'd0, bus.score_bcd}, 32'h9999);
        chk("sat_ovf",   {31'd0, bus.overflow},  32'd1);

        // game_over to high update latency
        bus.game_over = 1'b1;
        step(1);
        chk("go_high_c1", {16'd0, bus.high_bcd}, 32'h0340);
        step(1);
        chk("go_high_c2", {16'd0, bus.high_bcd}, 32'h9999);
        do_ng();
        chk("ng_score", {16'd0, bus.score_bcd}, 32'd0);
        chk("ng_ovf",   {31'd0, bus.overflow},  32'd0);
        chk("ng_high",  {16'd0, bus.high_bcd},  32'h9999);

        // new_game coincident with frame_tick drops the frame
        bus.displacement = 8'd77;
        bus.frame_clk    = 1'b1;
        step(3);
        bus.new_game = 1'b1;
        step(1);
        bus.new_game  = 1'b0;
        bus.frame_clk = 1'b0;
        step(30);
        chk("ng_tick_score", {16'd0, bus.score_bcd}, 32'd0);
        chk("ng_tick_busy",  {31'd0, bus.busy},      32'd0);

        // Second frame lands mid-drain
        bus.displacement = 8'd200;
        bus.frame_clk    = 1'b1;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            step(1);
            if (cyc == 6)   bus.frame_clk = 1'b0;
            if (cyc == 100) bus.frame_clk = 1'b1;
            if (cyc == 106) bus.frame_clk = 1'b0;
            if (cyc > 110 && !bus.busy) break;
        end
        chk("overlap_score", {16'd0, bus.score_bcd}, 32'h0400);
        chk("overlap_busy",  {31'd0, bus.busy},      32'd0);

        // Asynchronous reset in the middle of a drain
        bus.displacement = 8'd100;
        bus.frame_clk    = 1'b1;
        step(6);
        bus.frame_clk = 1'b0;
        step(6);
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_score", {16'd0, bus.score_bcd}, 32'd0);
        chk("arst_high",  {16'd0, bus.high_bcd},  32'd0);
        chk("arst_busy",  {31'd0, bus.busy},      32'd0);
        chk("arst_ovf",   {31'd0, bus.overflow},  32'd0);
        step(2);
        Reset_n = 1'b1;
        step(2);

        m_score = 0; m_high = 0; m_ovf = 1'b0; m_go = 1'b0;
        for (int it = 0; it < 40; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      apply(OP_GO, 0);
            else if (r <= 2) apply(OP_NG, 0);
            else             apply(OP_VS, int'($urandom_range(0, 255)));
            chk($sformatf("rnd%0d_score", it), {16'd0, bus.score_bcd}, {16'd0, to_bcd(m_score)});
            chk($sformatf("rnd%0d_high", it),  {16'd0, bus.high_bcd},  {16'd0, to_bcd(m_high)});
            chk($sformatf("rnd%0d_ovf", it),   {31'd0, bus.overflow},  {31'd0, m_ovf});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
